// File: rtl/ltc2324_16_emu.sv
// Device-side emulator of the LTC2324-16 quad-channel serial ADC interface.
// Define LTC2324_EMU_PATTERN_EN to replace the repeat-last-word underrun fallback with a ramp generator.
module ltc2324_16_emu #(
    parameter int CONV_CYCLES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        CNV,
    input  logic        SCK,
    output logic        CLKOUT,
    output logic        SDO1,
    output logic        SDO2,
    output logic        SDO3,
    output logic        SDO4,
    input  logic [63:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        err_underrun,
    output logic        err_sck_early,
    output logic        err_abort,
    input  logic        clr_err
);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_READY, S_SHIFT} state_t;

    localparam logic [7:0] CONV_LOAD = 8'(CONV_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [7:0]  conv_cnt_reg, conv_cnt_next;
    logic [4:0]  bit_cnt_reg, bit_cnt_next;
    logic [2:0]  cnv_sync_reg, sck_sync_reg;
    logic        cnv_rise_reg, sck_fall_reg;
    logic [63:0] hold_reg;
    logic        hold_full_reg;
    logic [15:0] frame_cnt_reg;
    logic        err_underrun_reg, err_sck_early_reg, err_abort_reg;
    logic [63:0] fallback_word, load_word;
    logic        cnv_fire, hold_load, shift_en, frame_done, sdo_en, busy_int;
    logic        underrun_set, abort_set, sck_early_set;
    logic [3:0]  sdo_vec;

    // Index 0 = s1, 1 = s2, 2 = s3 (history). Edge pulses are registered once more.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnv_sync_reg <= '0;
            sck_sync_reg <= '0;
            cnv_rise_reg <= 1'b0;
            sck_fall_reg <= 1'b0;
        end else begin
            cnv_sync_reg <= {cnv_sync_reg[1:0], CNV};
            sck_sync_reg <= {sck_sync_reg[1:0], SCK};
            cnv_rise_reg <= cnv_sync_reg[1] & ~cnv_sync_reg[2];
            sck_fall_reg <= ~sck_sync_reg[1] & sck_sync_reg[2];
        end
    end

    assign cnv_fire  = cnv_rise_reg;
    assign CLKOUT    = sck_sync_reg[2];
    assign s_ready   = ~hold_full_reg | cnv_fire;
    assign hold_load = s_valid & s_ready;
    assign load_word = hold_full_reg ? hold_reg : fallback_word;

    // A CNV edge consumes the old contents while a same-cycle handshake refills the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
        end else begin
            if (hold_load) begin
                hold_reg      <= s_data;
                hold_full_reg <= 1'b1;
            end else if (cnv_fire) begin
                hold_full_reg <= 1'b0;
            end
        end
    end

`ifdef LTC2324_EMU_PATTERN_EN
    logic [15:0] pat_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pat_reg <= '0;
        else if (cnv_fire && !hold_full_reg)
            pat_reg <= pat_reg + 16'd1;
    end

    assign fallback_word = {pat_reg, pat_reg + 16'h1000, pat_reg + 16'h2000, pat_reg + 16'h3000};
`else
    logic [63:0] last_word_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_word_reg <= '0;
        else if (cnv_fire)
            last_word_reg <= load_word;
    end

    assign fallback_word = last_word_reg;
`endif

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ch
            logic [15:0] sr_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    sr_reg <= '0;
                else if (cnv_fire)
                    sr_reg <= load_word[63 - 16*gi -: 16];
                else if (shift_en)
                    sr_reg <= {sr_reg[14:0], 1'b0};
            end

            assign sdo_vec[gi] = sdo_en & sr_reg[15];
        end
    endgenerate

    assign SDO1 = sdo_vec[0];
    assign SDO2 = sdo_vec[1];
    assign SDO3 = sdo_vec[2];
    assign SDO4 = sdo_vec[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            conv_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            conv_cnt_reg <= conv_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        conv_cnt_next = conv_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_en      = 1'b0;
        frame_done    = 1'b0;
        busy_int      = (state_reg == S_CONV);
        sdo_en        = (state_reg == S_READY) || (state_reg == S_SHIFT);
        // A CNV edge restarts the conversion from any state; an open frame is dropped.
        if (cnv_fire) begin
            state_next    = S_CONV;
            conv_cnt_next = CONV_LOAD;
            bit_cnt_next  = '0;
        end else begin
            case (state_reg)
                S_CONV: begin
                    if (conv_cnt_reg == 8'd0)
                        state_next = S_READY;
                    else
                        conv_cnt_next = conv_cnt_reg - 8'd1;
                end
                S_READY, S_SHIFT: begin
                    if (sck_fall_reg) begin
                        shift_en     = 1'b1;
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                        if (bit_cnt_reg == 5'd15) begin
                            state_next = S_IDLE;
                            frame_done = 1'b1;
                        end else begin
                            state_next = S_SHIFT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy          = busy_int;
    assign underrun_set  = cnv_fire & ~hold_full_reg;
    assign abort_set     = cnv_fire & (state_reg != S_IDLE);
    assign sck_early_set = sck_fall_reg & (state_reg == S_CONV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg     <= '0;
            err_underrun_reg  <= 1'b0;
            err_sck_early_reg <= 1'b0;
            err_abort_reg     <= 1'b0;
        end else begin
            if (frame_done)
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            if (underrun_set)
                err_underrun_reg <= 1'b1;
            else if (clr_err)
                err_underrun_reg <= 1'b0;
            if (sck_early_set)
                err_sck_early_reg <= 1'b1;
            else if (clr_err)
                err_sck_early_reg <= 1'b0;
            if (abort_set)
                err_abort_reg <= 1'b1;
            else if (clr_err)
                err_abort_reg <= 1'b0;
        end
    end

    assign frame_cnt     = frame_cnt_reg;
    assign err_underrun  = err_underrun_reg;
    assign err_sck_early = err_sck_early_reg;
    assign err_abort     = err_abort_reg;

endmodule
